// File: rtl/osd_spi_master.sv
// osd_spi_master: SPI mode-0 write-only master for an OSD controller.
// A command byte is followed by `len` payload bytes pulled through a
// valid/ready handshake. Every output is driven straight from a flop.
// Optional feature: define OSD_SPI_PREFETCH_EN to add a one-byte holding
// register that is filled while the current byte shifts, so a byte supplied
// early costs no FETCH cycle.
module osd_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 11
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             SPI_SCK,
    output logic             SPI_SS3,
    output logic             SPI_DO
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FETCH = 3'd3,
        ST_END   = 3'd4
    } state_t;

    // Last count value of an SCK half-period.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             sck_q, sck_d;
    logic             do_q, do_d;
    logic             ss3_q, ss3_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             phase_end_s;
    logic             hs_s;
    logic             byte_avail_s;
    logic [7:0]       next_byte_s;
    logic             load_s;

`ifdef OSD_SPI_PREFETCH_EN
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
`endif

    assign phase_end_s = (cnt_q == DIV_LAST);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rem_d        = rem_q;
        sck_d        = sck_q;
        do_d         = do_q;
        done_d       = 1'b0;
        load_s       = 1'b0;
        hs_s         = data_valid & ready_q;
`ifdef OSD_SPI_PREFETCH_EN
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (hs_s) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
        end else begin
            hold_d       = hold_q;
        end
        byte_avail_s = hold_valid_d;
        next_byte_s  = hold_d;
`else
        // Without prefetch a handshake can only happen in FETCH.
        byte_avail_s = hs_s;
        next_byte_s  = data_in;
`endif

        case (state_q)
            ST_IDLE: begin
                sck_d = 1'b0;
                do_d  = 1'b0;
                if (start) begin
                    state_d   = ST_SETUP;
                    shreg_d   = cmd;
                    do_d      = cmd[7];
                    rem_d     = len;
                    bit_cnt_d = 3'd7;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d     = 8'd0;
                end
            end
            ST_SETUP: begin
                if (phase_end_s) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (!phase_end_s) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else if (bit_cnt_q != 3'd0) begin
                        // DO only moves on the first cycle of a low phase.
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        do_d      = shreg_q[6];
                    end else if (rem_q == '0) begin
                        sck_d   = 1'b0;
                        state_d = ST_END;
                    end else if (byte_avail_s) begin
                        load_s  = 1'b1;
                    end else begin
                        sck_d   = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // SCK low and DO held for as long as the source stalls.
                sck_d = 1'b0;
                if (byte_avail_s) begin
                    load_s = 1'b1;
                end else begin
                    cnt_d  = 8'd0;
                end
            end
            ST_END: begin
                if (phase_end_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    do_d    = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sck_d   = 1'b0;
                do_d    = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase

        // Start the low phase of the next payload byte.
        if (load_s) begin
            state_d   = ST_SHIFT;
            shreg_d   = next_byte_s;
            do_d      = next_byte_s[7];
            rem_d     = rem_q - LEN_W'(1);
            bit_cnt_d = 3'd7;
            sck_d     = 1'b0;
            cnt_d     = 8'd0;
`ifdef OSD_SPI_PREFETCH_EN
            hold_valid_d = 1'b0;
`endif
        end else begin
            rem_d = rem_d;
        end

        ss3_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
`ifdef OSD_SPI_PREFETCH_EN
        ready_d = (state_d == ST_FETCH) ||
                  (((state_d == ST_SETUP) || (state_d == ST_SHIFT)) &&
                   (rem_d != '0) && !hold_valid_d);
`else
        ready_d = (state_d == ST_FETCH);
`endif
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            rem_q     <= '0;
            sck_q     <= 1'b0;
            do_q      <= 1'b0;
            ss3_q     <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef OSD_SPI_PREFETCH_EN
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rem_q     <= rem_d;
            sck_q     <= sck_d;
            do_q      <= do_d;
            ss3_q     <= ss3_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef OSD_SPI_PREFETCH_EN
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
`endif
        end
    end

    assign data_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign SPI_SCK    = sck_q;
    assign SPI_SS3    = ss3_q;
    assign SPI_DO     = do_q;

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: two instances (CLK_DIV=1 and CLK_DIV=2), a
// serial receiver model feeding a scoreboard of expected frames, and a
// data source with programmable stall.
module tb_osd_spi_master;

`ifdef OSD_SPI_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start2;
    logic [7:0]  cmd, din;
    logic [10:0] len;
    logic        dv;
    logic        rdy1, busy1, done1, sck1, ss1, do1;
    logic        rdy2, busy2, done2, sck2, ss2, do2;

    osd_spi_master #(.CLK_DIV(1), .LEN_W(11)) u_dut1 (
        .clk_sys(clk), .reset(rst), .start(start1), .cmd(cmd), .len(len),
        .data_in(din), .data_valid(dv), .data_ready(rdy1), .busy(busy1),
        .done(done1), .SPI_SCK(sck1), .SPI_SS3(ss1), .SPI_DO(do1));

    osd_spi_master #(.CLK_DIV(2), .LEN_W(11)) u_dut2 (
        .clk_sys(clk), .reset(rst), .start(start2), .cmd(cmd), .len(len),
        .data_in(din), .data_valid(dv), .data_ready(rdy2), .busy(busy2),
        .done(done2), .SPI_SCK(sck2), .SPI_SS3(ss2), .SPI_DO(do2));

    // Observed instance: 0 -> u_dut1, 1 -> u_dut2.
    logic sel;
    logic m_rdy, m_busy, m_done, m_sck, m_ss3, m_do;
    assign m_rdy  = sel ? rdy2  : rdy1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_sck  = sel ? sck2  : sck1;
    assign m_ss3  = sel ? ss2   : ss1;
    assign m_do   = sel ? do2   : do1;

    typedef struct {
        int          nbits;
        logic [63:0] bits;
        int          ss3_len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] feed_q[$];
    int         stall = 0;
    int         n_vec = 0;
    int         n_err = 0;

    logic [63:0] acc;
    int          nb;
    int          lowc;
    logic        prev_sck;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Receiver model and scoreboard monitor.
    initial begin
        exp_t e;
        acc = '0; nb = 0; lowc = 0; prev_sck = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = '0; nb = 0; lowc = 0; prev_sck = 1'b0;
            end else begin
                if (!m_ss3) lowc++;
                if (m_sck && !prev_sck) begin
                    acc = {acc[62:0], m_do};
                    nb++;
                end
                prev_sck = m_sck;
                if (m_done) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_done: got done, required none");
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bitcount", 64'(nb), 64'(e.nbits));
                        check("frame_bits", acc, e.bits);
                        check("ss3_low_cycles", 64'(lowc), 64'(e.ss3_len));
                        check("busy_at_done", 64'(m_busy), 64'd0);
                    end
                    acc = '0; nb = 0; lowc = 0;
                end
            end
        end
    end

    // Payload source: presents feed_q bytes, optionally stalling while ready.
    initial begin
        logic hs_prev;
        logic last_do;
        hs_prev = 1'b0;
        last_do = 1'b0;
        dv = 1'b0;
        din = 8'h00;
        forever begin
            @(negedge clk);
            if (hs_prev && feed_q.size() > 0) void'(feed_q.pop_front());
            if (rst || feed_q.size() == 0) begin
                dv = 1'b0;
            end else if (m_rdy && stall > 0) begin
                stall--;
                dv = 1'b0;
`ifndef OSD_SPI_PREFETCH_EN
                check("stall_sck", 64'(m_sck), 64'd0);
                check("stall_ss3", 64'(m_ss3), 64'd0);
                check("stall_do", 64'(m_do), 64'(last_do));
`endif
            end else begin
                dv  = 1'b1;
                din = feed_q[0];
            end
            hs_prev = dv && m_rdy && !rst;
            last_do = m_do;
        end
    end

    task automatic start_tx(input logic s, input logic [7:0] c, input logic [10:0] l,
                            input int ss3_len, input logic [63:0] bits, input int nbits);
        exp_t e;
        e.nbits = nbits; e.bits = bits; e.ss3_len = ss3_len;
        exp_q.push_back(e);
        sel = s; cmd = c; len = l;
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got %0d pending frames, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        cmd = 8'h00; len = 11'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset state of both instances.
        check("rst_ss3_1", 64'(ss1), 64'd1);   check("rst_ss3_2", 64'(ss2), 64'd1);
        check("rst_sck_1", 64'(sck1), 64'd0);  check("rst_sck_2", 64'(sck2), 64'd0);
        check("rst_do_1", 64'(do1), 64'd0);    check("rst_do_2", 64'(do2), 64'd0);
        check("rst_rdy_1", 64'(rdy1), 64'd0);  check("rst_rdy_2", 64'(rdy2), 64'd0);
        check("rst_busy_1", 64'(busy1), 64'd0); check("rst_busy_2", 64'(busy2), 64'd0);
        check("rst_done_1", 64'(done1), 64'd0); check("rst_done_2", 64'(done2), 64'd0);

        // Command only, CLK_DIV=2: 17*2 cycles of SS3 low.
        start_tx(1'b1, 8'h41, 11'd0, 34, 64'h41, 8);
        wait_idle();

        // Two payload bytes, CLK_DIV=1, data valid early.
        sel = 1'b0;
        feed_q.push_back(8'hA5); feed_q.push_back(8'h3C);
        start_tx(1'b0, 8'h20, 11'd2, PF ? 49 : 51, 64'h20A53C, 24);
        wait_idle();

        // Source stalls for 10 ready cycles.
        feed_q.push_back(8'h5A);
        stall = 10;
        start_tx(1'b0, 8'h81, 11'd1, PF ? 33 : 44, 64'h815A, 16);
        wait_idle();
        check("stall_consumed", 64'(stall), 64'd0);

        // Abort in the middle of payload byte 1, then a fresh transaction.
        feed_q.push_back(8'h11); feed_q.push_back(8'h22);
        feed_q.push_back(8'h33); feed_q.push_back(8'h44);
        cmd = 8'hC3; len = 11'd4; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 200 && nb < 12; i++) @(negedge clk);
        check("abort_reached_byte1", 64'(nb >= 12), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss3", 64'(ss1), 64'd1);
        check("abort_sck", 64'(sck1), 64'd0);
        check("abort_busy", 64'(busy1), 64'd0);
        check("abort_done", 64'(done1), 64'd0);
        feed_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        feed_q.push_back(8'h01); feed_q.push_back(8'h80);
        start_tx(1'b0, 8'h7E, 11'd2, PF ? 49 : 51, 64'h7E0180, 24);
        wait_idle();

        // Start pulses while busy are dropped.
        start_tx(1'b0, 8'h96, 11'd0, 17, 64'h96, 8);
        repeat (3) @(negedge clk);
        check("busy_during_tx", 64'(busy1), 64'd1);
        cmd = 8'hFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);

        // Back-to-back: next start issued in the done cycle.
        start_tx(1'b0, 8'h55, 11'd0, 17, 64'h55, 8);
        for (int i = 0; i < 200 && !done1; i++) @(negedge clk);
        check("b2b_first_done", 64'(done1), 64'd1);
        feed_q.push_back(8'hF0);
        start_tx(1'b0, 8'hAA, 11'd1, PF ? 33 : 34, 64'hAAF0, 16);
        wait_idle();
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
